uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 152 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, a small receive FIFO with a valid/ready pop port,
// and sticky framing/overrun flags.
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned FIFO_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frm_err,
    output logic       ovr_err,
    input  logic       err_clr,
    output logic       busy
);
    localparam int unsigned DIV_RAW = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned DEPTH   = 1 << FIFO_LOG2;
    localparam logic [PW-1:0] PMAX  = PW'(DIV - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic          sync1, sync2, rs;
    logic [2:0]    state;
    logic [PW-1:0] pcnt;
    logic [3:0]    scnt;
    logic [2:0]    bidx;
    logic [7:0]    shreg;
    logic          tick, start_ok, push, frm_set, ovr_set;

    logic [7:0]        mem [DEPTH];
    logic [FIFO_LOG2:0] wptr, rptr;
    logic              empty, full, pop, wr_en;

    // Preset to idle-high so a low rxd around reset release cannot look like a start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
        end
    end
    assign rs = sync2;

    assign tick     = (state != S_IDLE) && (pcnt == PMAX);
    assign start_ok = tick && (state == S_START) && (scnt == 4'd7) && !rs;
    assign push     = tick && (state == S_STOP) && (scnt == 4'd15) && rs;
    assign frm_set  = tick && (state == S_STOP) && (scnt == 4'd15) && !rs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            scnt <= '0;
        end else if (state == S_IDLE) begin
            pcnt <= '0;
            scnt <= '0;
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            if (start_ok)
                scnt <= '0;
            else if (tick)
                scnt <= scnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            bidx  <= '0;
            shreg <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!rs)
                        state <= S_START;
                end
                S_START: begin
                    if (tick && scnt == 4'd7) begin
                        state <= rs ? S_IDLE : S_DATA;
                        bidx  <= '0;
                    end
                end
                S_DATA: begin
                    if (tick && scnt == 4'd15) begin
                        shreg <= {rs, shreg[7:1]};
                        bidx  <= bidx + 1'b1;
                        if (bidx == 3'd7)
                            state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (tick && scnt == 4'd15)
                        state <= rs ? S_IDLE : S_BREAK;
                end
                S_BREAK: begin
                    if (rs)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

    assign empty    = (wptr == rptr);
    assign full     = (wptr[FIFO_LOG2] != rptr[FIFO_LOG2]) &&
                      (wptr[FIFO_LOG2-1:0] == rptr[FIFO_LOG2-1:0]);
    assign rx_valid = !empty;
    assign pop      = rx_valid && rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte
    assign wr_en    = push && (!full || pop);
    assign ovr_set  = push && full && !pop;
    assign rx_data  = mem[rptr[FIFO_LOG2-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wptr[FIFO_LOG2-1:0]] <= shreg;
                wptr <= wptr + 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_err <= 1'b0;
            ovr_err <= 1'b0;
        end else begin
            frm_err <= frm_set | (frm_err & ~err_clr);
            ovr_err <= ovr_set | (ovr_err & ~err_clr);
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial frames in, scoreboard monitor checks popped bytes.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    localparam int unsigned BIT_NS = 8680;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frm_err, ovr_err, busy;

    int         checks = 0;
    int         fails = 0;
    int         lat = 0;
    logic [7:0] exp_q [$];
    logic [7:0] fill_a [4] = '{8'h54, 8'h45, 8'h53, 8'h54};
    logic [7:0] fill_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    uart_rx_fifo #(.CLK_HZ(50000000), .BAUD(115200), .FIFO_LOG2(2)) dut (
        .clk(clk), .rst_n(rst_n), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frm_err(frm_err), .ovr_err(ovr_err), .err_clr(err_clr),
        .busy(busy)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves rxd at the stop level; the caller restores idle for a low stop bit
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            #(BIT_NS);
        end
        rxd = stop;
        #(BIT_NS);
    endtask

    always @(negedge clk) begin
        logic [7:0] e;
        if (rst_n && rx_valid && rx_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: got 0x%0h expected no byte", rx_data);
            end else begin
                e = exp_q.pop_front();
                if (rx_data !== e) begin
                    fails++;
                    $display("FAIL sb_data: got 0x%0h expected 0x%0h", rx_data, e);
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(5);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 8'h00);
        check("rst_frm", frm_err, 0);
        check("rst_ovr", ovr_err, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        cyc(3);

        // single byte and latency from the start edge
        exp_q.push_back(8'h54);
        fork
            send_frame(8'h54, 1'b1);
            begin
                while (lat < 6000) begin
                    @(posedge clk);
                    #1;
                    lat++;
                    if (rx_valid) break;
                end
            end
        join
        checks++;
        if (lat < 4105 || lat > 4109) begin
            fails++;
            $display("FAIL t1_latency: got %0d clocks expected about 4107", lat);
        end
        check("t1_valid", rx_valid, 1);
        check("t1_data", rx_data, 8'h54);
        check("t1_frm", frm_err, 0);
        check("t1_ovr", ovr_err, 0);
        check("t1_busy", busy, 0);
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
        check("t1_empty", rx_valid, 0);

        // fill to full, then overrun
        foreach (fill_a[i]) begin
            exp_q.push_back(fill_a[i]);
            send_frame(fill_a[i], 1'b1);
        end
        check("t2_valid", rx_valid, 1);
        check("t2_head", rx_data, 8'h54);
        send_frame(8'hAA, 1'b1);
        check("t3_ovr", ovr_err, 1);
        check("t3_head", rx_data, 8'h54);
        check("t3_frm", frm_err, 0);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        check("t3_ovr_clr", ovr_err, 0);
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t2_drain_valid", rx_valid, 1);
            cyc(1);
        end
        rx_ready = 1'b0;
        check("t2_drained", rx_valid, 0);

        // framing error, break, recovery
        send_frame(8'h55, 1'b0);
        check("t4_break_busy", busy, 1);
        check("t4_frm", frm_err, 1);
        check("t4_nopush", rx_valid, 0);
        rxd = 1'b1;
        cyc(4);
        check("t4_idle", busy, 0);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        check("t4_frm_clr", frm_err, 0);
        exp_q.push_back(8'h0D);
        send_frame(8'h0D, 1'b1);
        check("t4_valid", rx_valid, 1);
        check("t4_data", rx_data, 8'h0D);
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
        check("t4_empty", rx_valid, 0);

        // short low glitch on an idle line
        rxd = 1'b0;
        #2000;
        rxd = 1'b1;
        check("t5_busy_start", busy, 1);
        #(BIT_NS);
        check("t5_idle", busy, 0);
        check("t5_nopush", rx_valid, 0);
        check("t5_frm", frm_err, 0);
        check("t5_ovr", ovr_err, 0);

        // push on full coinciding with a pop
        foreach (fill_b[i]) begin
            exp_q.push_back(fill_b[i]);
            send_frame(fill_b[i], 1'b1);
        end
        exp_q.push_back(8'h99);
        fork
            send_frame(8'h99, 1'b1);
            begin
                repeat (lat - 1) @(posedge clk);
                #1;
                rx_ready = 1'b1;
                @(posedge clk);
                #1;
                rx_ready = 1'b0;
            end
        join
        check("t6_ovr", ovr_err, 0);
        check("t6_valid", rx_valid, 1);
        check("t6_head", rx_data, 8'h22);
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t6_drain_valid", rx_valid, 1);
            cyc(1);
        end
        rx_ready = 1'b0;
        check("t6_drained", rx_valid, 0);
        check("sb_leftover", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
